// File: rtl/conv_mac.sv
// 5x5 convolution MAC: one window row per cycle, rounded/shifted output, double-buffered coefficients.
// Define CONV_MAC_SAT_EN to saturate the result to the pixel range; otherwise it wraps.
package conv_pkg;
  typedef logic [7:0] pixel_t;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

module conv_mac
  import conv_pkg::*;
#(
  parameter int PIXEL_W = $bits(pixel_t),
  parameter int COEF_W  = 8,
  parameter int SHIFT   = 4
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   s_tvalid_i,
  input  logic [25*PIXEL_W-1:0]  s_tdata_i,
  input  logic                   s_tuser_i,
  input  logic                   s_tlast_i,
  output logic                   s_tready_o,
  output logic                   m_tvalid_o,
  output logic [PIXEL_W-1:0]     m_tdata_o,
  output logic                   m_tuser_o,
  output logic                   m_tlast_o,
  input  logic                   m_tready_i,
  input  logic                   coef_we_i,
  input  logic [4:0]             coef_addr_i,
  input  logic [COEF_W-1:0]      coef_dat_i,
  input  logic                   coef_commit_i,
  output logic                   busy_o
);
  localparam int NTAPS = 25;
  // One guard bit beyond the product width per doubling of 25 terms keeps the sum exact.
  localparam int ACC_W = PIXEL_W + COEF_W + 5;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << SHIFT);
  localparam logic signed [ACC_W:0]    HALF     = (ACC_W + 1)'(1 << (SHIFT - 1));

  state_t state, state_next;
  logic [25*PIXEL_W-1:0]     win_q;
  logic                      user_q, last_q;
  logic signed [COEF_W-1:0]  shadow [NTAPS];
  logic signed [COEF_W-1:0]  active [NTAPS];
  logic signed [ACC_W-1:0]   acc, row_sum;
  logic signed [ACC_W:0]     rounded;
  logic [PIXEL_W-1:0]        result;
  logic [4:0]                tap;
  logic [2:0]                row;
  logic                      pending, accept, copy, load_out;

  assign accept   = (state == IDLE) && s_tvalid_i;
  assign copy     = (state == IDLE) && !s_tvalid_i && pending;
  assign load_out = (state == DONE) && (!m_tvalid_o || m_tready_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (s_tvalid_i) state_next = ACC;
      ACC:     if (row == 3'd4) state_next = DONE;
      DONE:    if (!m_tvalid_o || m_tready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_tready_o = (state == IDLE);
    busy_o     = (state != IDLE) || pending;
  end

  // Window payload is only read after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q  <= s_tdata_i;
      user_q <= s_tuser_i;
      last_q <= s_tlast_i;
    end
  end

  always_comb begin
    row_sum = '0;
    tap     = '0;
    for (int c = 0; c < 5; c++) begin
      tap     = 5'(32'(row) * 5 + c);
      row_sum = row_sum + $signed({1'b0, win_q[tap*PIXEL_W +: PIXEL_W]}) * active[tap];
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      acc <= '0;
      row <= '0;
    end else if (accept) begin
      acc <= '0;
      row <= '0;
    end else if (state == ACC) begin
      acc <= acc + row_sum;
      row <= row + 3'd1;
    end
  end

  // Round half up, then arithmetic shift back to pixel scale.
  always_comb begin
    rounded = $signed({acc[ACC_W-1], acc}) + HALF;
`ifdef CONV_MAC_SAT_EN
    begin : sat
      localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << PIXEL_W) - 1);
      logic signed [ACC_W:0] shifted;
      shifted = rounded >>> SHIFT;
      if (shifted[ACC_W])          result = '0;
      else if (shifted > PIX_MAX)  result = '1;
      else                         result = shifted[PIXEL_W-1:0];
    end
`else
    result = PIXEL_W'(rounded >>> SHIFT);
`endif
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
    end else if (load_out) begin
      m_tvalid_o <= 1'b1;
      m_tdata_o  <= result;
      m_tuser_o  <= user_q;
      m_tlast_o  <= last_q;
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

  // NOTE: the coefficient banks are reset because they must power up as an identity filter.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      pending <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= (i == 12) ? COEF_ONE : '0;
        active[i] <= (i == 12) ? COEF_ONE : '0;
      end
    end else begin
      pending <= coef_commit_i || (pending && !copy);
      if (coef_we_i && coef_addr_i < 5'd25) shadow[coef_addr_i] <= coef_dat_i;
      if (copy)
        for (int i = 0; i < NTAPS; i++) active[i] <= shadow[i];
    end
  end
endmodule
